// File: rtl/vfd_scan_ctrl.sv
// vfd_scan_ctrl: per-grid VFD slot sequencer driving BLK/LAT/GCP strobes and GRAM-fed serial lanes.
module vfd_scan_ctrl #(
  parameter int LANES    = 3,
  parameter int GRIDS    = 52,
  parameter int ROWS     = 39,
  parameter int PERIOD   = 3840,
  parameter int BLK_LEN  = 120,
  parameter int LAT_LEN  = 3,
  parameter int GCP_STEP = 16,
  parameter int GCP_W    = 3,
  parameter int AW       = 13
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  output logic [AW-1:0]             GRAM_ADDR,
  output logic                      GRAM_RD,
  input  logic [LANES-1:0]          GRAM_DATA,
  output logic [LANES-1:0]          SOUT,
  output logic                      SCK,
  output logic                      LAT,
  output logic                      BLK,
  output logic                      GCP,
  output logic [$clog2(GRIDS)-1:0]  GRID,
  output logic                      FRAME
);
  localparam int PIX   = 6 * ROWS;
  localparam int BITS  = PIX + GRIDS;
  localparam int COLS  = 3 * GRIDS + 3;
  localparam int GW    = $clog2(GRIDS);
  localparam int TW    = $clog2(PERIOD + 1);
  localparam int NW    = $clog2(BITS + 1);
  localparam int PW    = $clog2(GCP_STEP + 1);
  localparam int S_END = BLK_LEN + 2 * BITS + 2;
  localparam int G0    = BLK_LEN + GCP_STEP;
  localparam int G1    = BLK_LEN + GCP_STEP * (2 ** LANES - 1);
  localparam logic [TW-1:0] TB = TW'(BLK_LEN);

  if (BLK_LEN + 2 * BITS + 2 > PERIOD) begin : g_bad_shift
    $error("vfd_scan_ctrl: shift window does not fit in PERIOD");
  end
  if (BLK_LEN + GCP_STEP * (2 ** LANES - 2) + GCP_W > PERIOD) begin : g_bad_gcp
    $error("vfd_scan_ctrl: GCP train does not fit in PERIOD");
  end
  if (LAT_LEN >= BLK_LEN) begin : g_bad_lat
    $error("vfd_scan_ctrl: LAT_LEN must be below BLK_LEN");
  end
  if (GRIDS < 4 || GRIDS % 2 != 0) begin : g_bad_grids
    $error("vfd_scan_ctrl: GRIDS must be even and at least 4");
  end
  if (ROWS * COLS > 2 ** AW) begin : g_bad_aw
    $error("vfd_scan_ctrl: AW too narrow for the pixel array");
  end

  typedef enum logic [1:0] {IDLE, BLANK, SHIFT, HOLD} state_t;
  state_t state;
  logic [TW-1:0] t, tn;
  logic [GW-1:0] gn;
  logic [31:0] tw;
  logic [PW-1:0] gph, gph_n;
  logic [NW-1:0] nb;
  logic [2:0] p, off;
  logic [AW-1:0] base;
  logic go, last, par, issue, upd, sck_n, pix_bit, grid_hit, pix, pm, gv;

  // All registered outputs are derived from the slot time of the cycle being entered (tn).
  always_comb begin
    last     = t == TW'(PERIOD - 1);
    go       = state == IDLE ? EN : (!last || EN);
    tn       = (state == IDLE || last) ? '0 : t + TW'(1);
    gn       = state == IDLE ? '0 : !last ? GRID : (GRID == GW'(GRIDS - 1) ? '0 : GRID + GW'(1));
    tw       = 32'(tn);
    par      = tn[0] == TB[0];
    issue    = tw >= BLK_LEN && tw < BLK_LEN + 2 * BITS && par;
    upd      = tw >= BLK_LEN + 2 && tw < S_END && par;
    sck_n    = tw >= BLK_LEN + 3 && tw < S_END && !par;
    gph_n    = (tw == BLK_LEN || gph == PW'(GCP_STEP - 1)) ? '0 : gph + PW'(1);
    off      = p[0] ? 3'd5 - {1'b0, p[2:1]} : {1'b0, p[2:1]};
    pix_bit  = 32'(nb) < PIX;
    grid_hit = 32'(nb) == PIX + 32'(GRID) ||
               (32'(nb) == PIX + 32'(GRID) + 1 && GRID != GW'(GRIDS - 1));
  end

  always_ff @(posedge CLK) begin
    if (RST || !go) begin
      state     <= IDLE;
      t         <= '0;
      GRID      <= '0;
      SOUT      <= '0;
      SCK       <= 1'b0;
      LAT       <= 1'b0;
      BLK       <= 1'b1;
      GCP       <= 1'b0;
      GRAM_RD   <= 1'b0;
      GRAM_ADDR <= '0;
      FRAME     <= 1'b0;
      gph       <= '0;
      nb        <= '0;
      p         <= '0;
      base      <= '0;
      pix       <= 1'b0;
      pm        <= 1'b0;
      gv        <= 1'b0;
    end else begin
      state   <= tw < BLK_LEN ? BLANK : tw < S_END ? SHIFT : HOLD;
      t       <= tn;
      GRID    <= gn;
      LAT     <= tw < LAT_LEN;
      BLK     <= tw < BLK_LEN;
      FRAME   <= tn == '0 && gn == '0;
      SCK     <= sck_n;
      gph     <= gph_n;
      GCP     <= tw >= G0 && tw < G1 && 32'(gph_n) < GCP_W;
      GRAM_RD <= issue && pix_bit;
      if (tn == '0) begin
        nb   <= '0;
        p    <= '0;
        base <= AW'(gn) + AW'({gn, 1'b0});
      end else if (issue) begin
        nb  <= nb + NW'(1);
        pix <= pix_bit;
        pm  <= p[0] == GRID[0];
        gv  <= grid_hit;
        if (pix_bit) begin
          GRAM_ADDR <= base + AW'(off);
          p         <= p == 3'd5 ? '0 : p + 3'd1;
          base      <= p == 3'd5 ? base + AW'(COLS) : base;
        end
      end
      if (upd)
        SOUT <= pix ? (pm ? GRAM_DATA : '0) : {LANES{gv}};
      else if (tw == S_END)
        SOUT <= '0;
    end
  end
endmodule

// File: tb/tb_vfd_scan_ctrl.sv
// tb_vfd_scan_ctrl: directed checks of slot framing, GRAM addressing/masking, grid bits, wrap/stop and reset abort.
module tb_vfd_scan_ctrl;
  localparam int LANES = 3, GRIDS = 4, ROWS = 2, PERIOD = 64, BLK_LEN = 8;
  localparam int LAT_LEN = 3, GCP_STEP = 4, GCP_W = 2, AW = 13;
  localparam int COLS = 3 * GRIDS + 3, PIX = 6 * ROWS, BITS = PIX + GRIDS;

  logic CLK = 1'b0, RST, EN;
  logic [AW-1:0] GRAM_ADDR;
  logic GRAM_RD, SCK, LAT, BLK, GCP, FRAME;
  logic [LANES-1:0] GRAM_DATA = '0, SOUT;
  logic [1:0] GRID;
  logic [23:0] pins;
  int vec = 0, errs = 0;

  localparam logic [23:0] IDLE_V = {3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 13'd0, 2'd0, 1'b0};

  vfd_scan_ctrl #(.LANES(LANES), .GRIDS(GRIDS), .ROWS(ROWS), .PERIOD(PERIOD), .BLK_LEN(BLK_LEN),
                  .LAT_LEN(LAT_LEN), .GCP_STEP(GCP_STEP), .GCP_W(GCP_W), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .GRAM_ADDR(GRAM_ADDR), .GRAM_RD(GRAM_RD), .GRAM_DATA(GRAM_DATA),
    .SOUT(SOUT), .SCK(SCK), .LAT(LAT), .BLK(BLK), .GCP(GCP), .GRID(GRID), .FRAME(FRAME));

  assign pins = {SOUT, SCK, LAT, BLK, GCP, GRAM_RD, GRAM_ADDR, GRID, FRAME};

  always #5 CLK = ~CLK;

  // Synchronous GRAM whose contents are the low address bits.
  always @(posedge CLK) GRAM_DATA <= GRAM_RD ? GRAM_ADDR[2:0] : GRAM_DATA;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int offt [6] = '{0, 5, 1, 4, 2, 3};
    logic [63:0] lat_e, blk_e, sck_e, gcp_e, rd_e;
    logic [63:0] lat_m, blk_m, sck_m, gcp_m, rd_m, frm_m;
    logic [2:0] sv [64];
    int rq [$];
    int g, cnt, addr, exp_s;
    lat_e = 64'h7;
    blk_e = 64'hFF;
    sck_e = '0;
    gcp_e = '0;
    rd_e  = '0;
    for (int n = 0; n < BITS; n++) sck_e[BLK_LEN + 3 + 2 * n] = 1'b1;
    for (int n = 0; n < PIX; n++) rd_e[BLK_LEN + 2 * n] = 1'b1;
    for (int k = 1; k <= 6; k++)
      for (int w = 0; w < GCP_W; w++) gcp_e[BLK_LEN + GCP_STEP * k + w] = 1'b1;
    RST = 1'b1;
    EN  = 1'b0;
    tick;
    tick;
    chk("reset_pins", pins, IDLE_V);
    RST = 1'b0;
    cnt = 0;
    repeat (100) begin
      tick;
      cnt += (SCK || !BLK || pins != IDLE_V) ? 1 : 0;
    end
    chk("idle_100_quiet", cnt, 0);
    EN = 1'b1;
    tick;
    for (int s = 0; s < 5; s++) begin
      lat_m = '0; blk_m = '0; sck_m = '0; gcp_m = '0; rd_m = '0; frm_m = '0;
      rq.delete();
      g = int'(GRID);
      for (int t = 0; t < PERIOD; t++) begin
        lat_m[t] = LAT;
        blk_m[t] = BLK;
        sck_m[t] = SCK;
        gcp_m[t] = GCP;
        rd_m[t]  = GRAM_RD;
        frm_m[t] = FRAME;
        sv[t]    = SOUT;
        if (GRAM_RD) rq.push_back(int'(GRAM_ADDR));
        if (s == 4 && t == 20) EN = 1'b0;
        tick;
      end
      chk($sformatf("s%0d_grid", s), g, s % GRIDS);
      chk($sformatf("s%0d_frame", s), frm_m, (s % GRIDS == 0) ? 64'h1 : 64'h0);
      chk($sformatf("s%0d_lat", s), lat_m, lat_e);
      chk($sformatf("s%0d_blk", s), blk_m, blk_e);
      chk($sformatf("s%0d_sck", s), sck_m, sck_e);
      chk($sformatf("s%0d_gcp", s), gcp_m, gcp_e);
      chk($sformatf("s%0d_rd", s), rd_m, rd_e);
      chk($sformatf("s%0d_sout_tail", s), sv[BLK_LEN + 2 * BITS + 2], 0);
      for (int n = 0; n < BITS; n++) begin
        if (n < PIX) begin
          addr = (n / 6) * COLS + 3 * g + offt[n % 6];
          chk($sformatf("s%0d_addr%0d", s, n), n < rq.size() ? rq[n] : -1, addr);
          exp_s = ((g % 2 == 0 && offt[n % 6] <= 2) || (g % 2 == 1 && offt[n % 6] >= 3)) ? addr % 8 : 0;
        end else
          exp_s = (n - PIX == g || (n - PIX == g + 1 && g + 1 < GRIDS)) ? 7 : 0;
        chk($sformatf("s%0d_sout%0d", s, n), sv[BLK_LEN + 3 + 2 * n], exp_s);
      end
    end
    chk("stop_pins", pins, IDLE_V);
    cnt = 0;
    repeat (10) begin
      tick;
      cnt += (pins != IDLE_V) ? 1 : 0;
    end
    chk("stop_stays_idle", cnt, 0);
    EN = 1'b1;
    tick;
    repeat (PERIOD + 25) tick;
    chk("pre_rst_grid", GRID, 1);
    chk("pre_rst_sck", SCK, 1);
    RST = 1'b1;
    tick;
    chk("rst_abort_pins", pins, IDLE_V);
    RST = 1'b0;
    tick;
    chk("restart_grid", GRID, 0);
    chk("restart_frame", FRAME, 1);
    chk("restart_lat_blk", {LAT, BLK}, 2'b11);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
